alu_komut_birimi: RTL and testbench
===================================

ALU_KOMUT_BIRIMI -- requirements
Module: alu_komut_birimi

Interface
REQ-001 The block SHALL have parameters: none; register count is fixed at 4 x 8 bits.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 komut_gecerli_in  input  1  command valid.
REQ-005 komut_in  input  9  command: [8:6] islem, [5:4] rd, [3:2] rs1, [1:0] rs2.
REQ-006 hazir_out  output  1  command ready; accepted when komut_gecerli_in & hazir_out at a rising edge.
REQ-007 yaz_gecerli_in  input  1  direct register-write request.
REQ-008 yaz_adr_in  input  2  direct-write register index.
REQ-009 yaz_veri_in  input  8  direct-write data.
REQ-010 islem_out  output  3  operation code driven to the ALU.
REQ-011 s1_out  output  8  ALU operand 1.
REQ-012 s2_out  output  8  ALU operand 2.
REQ-013 alu_s_in  input  8  ALU result, combinational function of islem_out/s1_out/s2_out.
REQ-014 sonuc_gecerli_out  output  1  one-cycle result-valid pulse.
REQ-015 sonuc_out  output  8  last written-back result, held until next result.
REQ-016 z_out  output  1  1 when sonuc_out == 8'h00, updated with sonuc_out.
REQ-017 oku_adr_in  input  2  observation read index.
REQ-018 oku_veri_out  output  8  combinational read of register[oku_adr_in].

Function
REQ-019 The FSM SHALL have states BOS (idle), OKU (operand fetch), YURUT (execute), YAZ (writeback report).
REQ-020 hazir_out SHALL be 1 only when state==BOS, rst==0 and yaz_gecerli_in==0.
REQ-021 BOS -> OKU on command acceptance; command fields SHALL be latched at that edge.
REQ-022 OKU -> YURUT unconditionally; at that edge islem_out<=islem, s1_out<=reg[rs1], s2_out<=reg[rs2].
REQ-023 YURUT -> YAZ unconditionally; at that edge reg[rd]<=alu_s_in, sonuc_out<=alu_s_in, z_out<=(alu_s_in==0).
REQ-024 In YAZ sonuc_gecerli_out SHALL be 1; YAZ -> BOS unconditionally; sonuc_gecerli_out SHALL be 0 in every other state.
REQ-025 Latency: acceptance at edge E0 -> sonuc_gecerli_out high in the cycle between E2 and E3; throughput one command per 4 cycles.
REQ-026 islem_out/s1_out/s2_out SHALL hold their values from OKU->YURUT until the next OKU->YURUT edge.
REQ-027 Operands SHALL be read before writeback; rd equal to rs1 or rs2 SHALL use the old value.
REQ-028 All arithmetic is the ALU's; the block SHALL store alu_s_in unmodified (8-bit wrap, e.g. 8'hFF+1 = 8'h00).
REQ-029 A direct write SHALL occur only in BOS with rst==0: reg[yaz_adr_in]<=yaz_veri_in; yaz_gecerli_in in other states SHALL be ignored.
REQ-030 Simultaneous yaz_gecerli_in and komut_gecerli_in in BOS: write performed, command not accepted (hazir_out==0).
REQ-031 komut_gecerli_in while busy SHALL be ignored with no state effect.

Reset
REQ-032 rst==1 at a rising edge SHALL force state BOS, all 4 registers 8'h00, islem_out 3'b000, s1_out/s2_out/sonuc_out 8'h00, z_out 0, sonuc_gecerli_out 0.
REQ-033 rst SHALL override any in-flight command in any state; no writeback or result pulse SHALL follow.
REQ-034 hazir_out SHALL be 0 while rst==1 and 1 in the first cycle after rst deasserts (yaz_gecerli_in==0).

Verification
REQ-035 Direct writes R0=8'h05, R1=8'h03; command islem=000 rd=2 rs1=0 rs2=1 -> s1_out=05, s2_out=03, islem_out=000, sonuc_out=08, z_out=0, pulse 2 cycles after acceptance, oku R2=08.
REQ-036 R1=8'h03; islem=001 rd=3 rs1=1 rs2=1 -> sonuc_out=00, z_out=1, R3=00.
REQ-037 R0=8'hFF; islem=010 rd=0 rs1=0 -> sonuc_out=00, z_out=1, R0=00 (wrap, rd==rs1 uses old FF).
REQ-038 Command held valid continuously -> accepted only every 4th cycle; hazir_out=0 in OKU/YURUT/YAZ; yaz_gecerli_in asserted in YURUT with adr=1 data=AA -> R1 unchanged.
REQ-039 Same-cycle yaz_gecerli_in (adr=0, data=11) and command in BOS -> R0=11, command accepted next cycle only.
REQ-040 rst pulsed during YURUT of an ADD -> no sonuc_gecerli_out pulse, all registers and outputs 00, hazir_out=1 the cycle after rst drops.

Source files
------------

// File: rtl/alu_komut_birimi.sv
// -----------------------------------------------------------------------------
// alu_komut_birimi
// Command sequencer for an external combinational ALU. It holds a 4 x 8-bit
// register file. Each accepted command walks four states:
//   BOS   : idle. The block accepts a command here, or performs a direct write.
//   OKU   : operand fetch. The register file is read into s1/s2.
//   YURUT : execute. The ALU result is written back to rd.
//   YAZ   : result report. sonuc_gecerli_out is high for this one cycle.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   komut_gecerli_in    command valid
//   komut_in[8:0]       {islem[2:0], rd[1:0], rs1[1:0], rs2[1:0]}
//   hazir_out           command ready (combinational)
//   yaz_gecerli_in      direct register-write request (honoured only in BOS)
//   yaz_adr_in/veri_in  direct-write index / data
//   islem_out           operation code to the ALU (registered)
//   s1_out, s2_out      ALU operands (registered)
//   alu_s_in            ALU result
//   sonuc_gecerli_out   one-cycle result-valid pulse
//   sonuc_out, z_out    last written-back result and its zero flag
//   oku_adr_in          observation read index
//   oku_veri_out        combinational read of register[oku_adr_in]
// -----------------------------------------------------------------------------
module alu_komut_birimi (
    input  logic       clk,
    input  logic       rst,
    input  logic       komut_gecerli_in,
    input  logic [8:0] komut_in,
    output logic       hazir_out,
    input  logic       yaz_gecerli_in,
    input  logic [1:0] yaz_adr_in,
    input  logic [7:0] yaz_veri_in,
    output logic [2:0] islem_out,
    output logic [7:0] s1_out,
    output logic [7:0] s2_out,
    input  logic [7:0] alu_s_in,
    output logic       sonuc_gecerli_out,
    output logic [7:0] sonuc_out,
    output logic       z_out,
    input  logic [1:0] oku_adr_in,
    output logic [7:0] oku_veri_out
);

    typedef enum logic [1:0] {
        BOS   = 2'd0,
        OKU   = 2'd1,
        YURUT = 2'd2,
        YAZ   = 2'd3
    } durum_t;

    durum_t     durum_r;
    durum_t     durum_s;
    logic [7:0] reg_r [4];
    logic [2:0] islem_r;
    logic [1:0] rd_r;
    logic [1:0] rs1_r;
    logic [1:0] rs2_r;
    logic [2:0] alu_islem_r;
    logic [7:0] s1_r;
    logic [7:0] s2_r;
    logic       sonuc_gecerli_r;
    logic [7:0] sonuc_r;
    logic       z_r;
    logic       hazir_s;
    logic       kabul_s;
    logic       dogrudan_yaz_s;

    function automatic logic sifir_mi(input logic [7:0] deger);
        return (deger == 8'h00);
    endfunction

    // Ready/accept/direct-write qualifiers. A direct write in BOS takes priority
    // over a command, so ready drops whenever a write is requested.
    always_comb begin
        hazir_s        = 1'b0;
        dogrudan_yaz_s = 1'b0;
        if ((durum_r == BOS) && !rst) begin
            hazir_s        = !yaz_gecerli_in;
            dogrudan_yaz_s = yaz_gecerli_in;
        end else begin
            hazir_s        = 1'b0;
            dogrudan_yaz_s = 1'b0;
        end
        kabul_s = hazir_s & komut_gecerli_in;
    end

    // Next-state logic.
    always_comb begin
        durum_s = durum_r;
        case (durum_r)
            BOS: begin
                if (kabul_s) begin
                    durum_s = OKU;
                end else begin
                    durum_s = BOS;
                end
            end
            OKU:     durum_s = YURUT;
            YURUT:   durum_s = YAZ;
            YAZ:     durum_s = BOS;
            default: durum_s = BOS;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            durum_r <= BOS;
        end else begin
            durum_r <= durum_s;
        end
    end

    // Latch the command fields at acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            islem_r <= 3'd0;
            rd_r    <= 2'd0;
            rs1_r   <= 2'd0;
            rs2_r   <= 2'd0;
        end else if (kabul_s) begin
            islem_r <= komut_in[8:6];
            rd_r    <= komut_in[5:4];
            rs1_r   <= komut_in[3:2];
            rs2_r   <= komut_in[1:0];
        end
    end

    // Operand fetch. The register file is read one cycle before writeback, so
    // an rd that matches rs1/rs2 still sees the old value.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_islem_r <= 3'd0;
            s1_r        <= 8'h00;
            s2_r        <= 8'h00;
        end else if (durum_r == OKU) begin
            alu_islem_r <= islem_r;
            s1_r        <= reg_r[rs1_r];
            s2_r        <= reg_r[rs2_r];
        end
    end

    // Register file: ALU writeback in YURUT, direct writes only from BOS.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                reg_r[i] <= 8'h00;
            end
        end else if (durum_r == YURUT) begin
            reg_r[rd_r] <= alu_s_in;
        end else if (dogrudan_yaz_s) begin
            reg_r[yaz_adr_in] <= yaz_veri_in;
        end
    end

    // Result capture and the pulse that marks the YAZ cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            sonuc_gecerli_r <= 1'b0;
            sonuc_r         <= 8'h00;
            z_r             <= 1'b0;
        end else begin
            sonuc_gecerli_r <= (durum_r == YURUT);
            if (durum_r == YURUT) begin
                sonuc_r <= alu_s_in;
                z_r     <= sifir_mi(alu_s_in);
            end
        end
    end

    assign hazir_out         = hazir_s;
    assign islem_out         = alu_islem_r;
    assign s1_out            = s1_r;
    assign s2_out            = s2_r;
    assign sonuc_gecerli_out = sonuc_gecerli_r;
    assign sonuc_out         = sonuc_r;
    assign z_out             = z_r;
    assign oku_veri_out      = reg_r[oku_adr_in];

endmodule

// File: tb/tb_alu_komut_birimi.sv
// -----------------------------------------------------------------------------
// tb_alu_komut_birimi
// Directed bench for alu_komut_birimi. A small ALU stand-in drives alu_s_in.
// The bench keeps a model of the register file. Expected results are queued
// when each command is accepted, and they are popped when the DUT reports a
// result.
// -----------------------------------------------------------------------------
module tb_alu_komut_birimi;

    logic       clk = 1'b0;
    logic       rst;
    logic       komut_gecerli;
    logic [8:0] komut;
    logic       hazir;
    logic       yaz_gecerli;
    logic [1:0] yaz_adr;
    logic [7:0] yaz_veri;
    logic [2:0] islem;
    logic [7:0] s1;
    logic [7:0] s2;
    logic [7:0] alu_s;
    logic       sonuc_gecerli;
    logic [7:0] sonuc;
    logic       z;
    logic [1:0] oku_adr;
    logic [7:0] oku_veri;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] mreg [4];
    logic [7:0] exp_q [$];
    logic [2:0] e_islem;
    logic [7:0] e_s1;
    logic [7:0] e_s2;
    logic [1:0] e_rd;

    alu_komut_birimi dut (
        .clk               (clk),
        .rst               (rst),
        .komut_gecerli_in  (komut_gecerli),
        .komut_in          (komut),
        .hazir_out         (hazir),
        .yaz_gecerli_in    (yaz_gecerli),
        .yaz_adr_in        (yaz_adr),
        .yaz_veri_in       (yaz_veri),
        .islem_out         (islem),
        .s1_out            (s1),
        .s2_out            (s2),
        .alu_s_in          (alu_s),
        .sonuc_gecerli_out (sonuc_gecerli),
        .sonuc_out         (sonuc),
        .z_out             (z),
        .oku_adr_in        (oku_adr),
        .oku_veri_out      (oku_veri)
    );

    always #5 clk = ~clk;

    // ALU stand-in: 0 add, 1 sub, 2 increment s1, 3 and, 4 or, 5 xor, 6 not, 7 pass s2.
    function automatic logic [7:0] alu_model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a + 8'd1;
            3'd3:    return a & b;
            3'd4:    return a | b;
            3'd5:    return a ^ b;
            3'd6:    return ~a;
            3'd7:    return b;
            default: return 8'h00;
        endcase
    endfunction

    always_comb alu_s = alu_model(islem, s1, s2);

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic direct_write(input logic [1:0] a, input logic [7:0] d);
        yaz_gecerli = 1'b1;
        yaz_adr     = a;
        yaz_veri    = d;
        tick();
        yaz_gecerli = 1'b0;
        mreg[a]     = d;
        oku_adr     = a;
        #1;
        chk("direct_write_readback", oku_veri, d);
    endtask

    task automatic accept_cmd(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1, input logic [1:0] rs2);
        e_islem = op;
        e_s1    = mreg[rs1];
        e_s2    = mreg[rs2];
        e_rd    = rd;
        exp_q.push_back(alu_model(op, e_s1, e_s2));
        komut         = {op, rd, rs1, rs2};
        komut_gecerli = 1'b1;
        #1;
        chk("hazir_in_bos", 8'(hazir), 8'd1);
        tick();
        komut_gecerli = 1'b0;
        #1;
        chk("hazir_in_oku", 8'(hazir), 8'd0);
        chk("pulse_in_oku", 8'(sonuc_gecerli), 8'd0);
    endtask

    task automatic wait_result();
        int         n;
        logic [7:0] e;
        n = 0;
        do begin
            tick();
            n++;
            if (n == 1) begin
                chk("islem_out", 8'(islem), 8'(e_islem));
                chk("s1_out", s1, e_s1);
                chk("s2_out", s2, e_s2);
                chk("hazir_in_yurut", 8'(hazir), 8'd0);
            end
        end while (!sonuc_gecerli && n < 6);
        chk("pulse_latency", 8'(n), 8'd2);
        if (sonuc_gecerli) begin
            chk("scoreboard_nonempty", 8'(exp_q.size() != 0), 8'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sonuc_out", sonuc, e);
                chk("z_out", 8'(z), 8'(e == 8'h00));
                chk("hazir_in_yaz", 8'(hazir), 8'd0);
                mreg[e_rd] = e;
                tick();
                chk("pulse_single_cycle", 8'(sonuc_gecerli), 8'd0);
                chk("hazir_after_yaz", 8'(hazir), 8'd1);
                chk("sonuc_held", sonuc, e);
                oku_adr = e_rd;
                #1;
                chk("oku_rd", oku_veri, e);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] e;
        logic [7:0] loop_exp;
        rst           = 1'b1;
        komut_gecerli = 1'b0;
        komut         = 9'd0;
        yaz_gecerli   = 1'b0;
        yaz_adr       = 2'd0;
        yaz_veri      = 8'h00;
        oku_adr       = 2'd0;
        for (int i = 0; i < 4; i++) mreg[i] = 8'h00;

        // Reset state
        tick();
        tick();
        chk("rst_hazir", 8'(hazir), 8'd0);
        chk("rst_pulse", 8'(sonuc_gecerli), 8'd0);
        chk("rst_sonuc", sonuc, 8'h00);
        chk("rst_z", 8'(z), 8'd0);
        chk("rst_s1", s1, 8'h00);
        chk("rst_islem", 8'(islem), 8'd0);
        rst = 1'b0;
        #1;
        chk("hazir_after_rst", 8'(hazir), 8'd1);

        // Add: R2 = R0 + R1
        direct_write(2'd0, 8'h05);
        direct_write(2'd1, 8'h03);
        accept_cmd(3'd0, 2'd2, 2'd0, 2'd1);
        wait_result();

        // Sub to zero
        accept_cmd(3'd1, 2'd3, 2'd1, 2'd1);
        wait_result();

        // Increment with wrap, rd == rs1
        direct_write(2'd0, 8'hFF);
        accept_cmd(3'd2, 2'd0, 2'd0, 2'd0);
        wait_result();

        // A couple of other patterns
        direct_write(2'd0, 8'hC3);
        accept_cmd(3'd5, 2'd1, 2'd0, 2'd2);
        wait_result();
        accept_cmd(3'd0, 2'd3, 2'd1, 2'd1);
        wait_result();

        // Command held valid for 12 cycles; direct write in YURUT is ignored
        loop_exp = alu_model(3'd0, mreg[0], mreg[3]);
        komut    = {3'd0, 2'd2, 2'd0, 2'd3};
        for (int c = 0; c < 12; c++) begin
            komut_gecerli = 1'b1;
            yaz_gecerli   = ((c % 4) == 2);
            yaz_adr       = 2'd1;
            yaz_veri      = 8'hAA;
            #1;
            chk("held_hazir", 8'(hazir), 8'((c % 4) == 0));
            chk("held_pulse", 8'(sonuc_gecerli), 8'((c % 4) == 3));
            if (sonuc_gecerli && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("held_sonuc", sonuc, e);
            end
            if (hazir) exp_q.push_back(loop_exp);
            tick();
        end
        komut_gecerli = 1'b0;
        yaz_gecerli   = 1'b0;
        mreg[2]       = loop_exp;
        oku_adr       = 2'd1;
        #1;
        chk("busy_write_ignored", oku_veri, mreg[1]);
        oku_adr = 2'd2;
        #1;
        chk("held_r2", oku_veri, mreg[2]);
        chk("held_queue_empty", 8'(exp_q.size()), 8'd0);

        // Simultaneous write and command in BOS
        komut         = {3'd0, 2'd3, 2'd0, 2'd0};
        komut_gecerli = 1'b1;
        yaz_gecerli   = 1'b1;
        yaz_adr       = 2'd0;
        yaz_veri      = 8'h11;
        #1;
        chk("collide_hazir", 8'(hazir), 8'd0);
        tick();
        yaz_gecerli = 1'b0;
        mreg[0]     = 8'h11;
        #1;
        chk("collide_not_accepted", 8'(hazir), 8'd1);
        oku_adr = 2'd0;
        #1;
        chk("collide_r0", oku_veri, 8'h11);
        accept_cmd(3'd0, 2'd3, 2'd0, 2'd0);
        wait_result();

        // Reset during YURUT of an add
        accept_cmd(3'd0, 2'd1, 2'd0, 2'd0);
        tick();
        rst = 1'b1;
        #1;
        chk("hazir_during_rst", 8'(hazir), 8'd0);
        tick();
        exp_q.delete();
        for (int i = 0; i < 4; i++) mreg[i] = 8'h00;
        chk("abort_pulse", 8'(sonuc_gecerli), 8'd0);
        chk("abort_islem", 8'(islem), 8'd0);
        chk("abort_s1", s1, 8'h00);
        chk("abort_s2", s2, 8'h00);
        chk("abort_sonuc", sonuc, 8'h00);
        chk("abort_z", 8'(z), 8'd0);
        for (int i = 0; i < 4; i++) begin
            oku_adr = 2'(i);
            #1;
            chk("abort_reg", oku_veri, 8'h00);
        end
        rst = 1'b0;
        #1;
        chk("abort_hazir_after", 8'(hazir), 8'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("abort_no_pulse", 8'(sonuc_gecerli), 8'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
